// File: rtl/wb_regfile.sv
// wb_regfile -- MIPS write-back stage and 32x32 architectural register file.
//
// Picks the write-back value from the MEM/WB register and commits it to the
// register file on the rising clock edge. It also serves the two combinational
// ID-stage read ports, exports the write-back value for EX forwarding, and
// counts committed writes.
//
// Optional feature: define WB_BYPASS_EN for write-first read ports. A read of
// the register being committed then returns WrData in the same cycle. When the
// macro is undefined, the read ports return stored contents only, and the
// hazard unit must stall ID on an AddrC match.
//
// Ports
//   clk           clock; all writes on the rising edge
//   reset         asynchronous, active-low reset
//   RegWr         write enable from MEM/WB
//   MemToReg      write-back source: 00/11 ALUOut, 01 ReadData, 10 pc_plus_4
//   AddrC         destination register
//   ALUOut        ALU result
//   ReadData      data-memory load result
//   pc_plus_4     link address (jal/jalr)
//   AddrA, AddrB  read port addresses (rs, rt)
//   DataA, DataB  read port data; $0 always reads 0
//   WrData        selected write-back value
//   wb_commit_cnt number of committed register writes; wraps silently
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWr,
  input  logic [1:0]        MemToReg,
  input  logic [ADDR_W-1:0] AddrC,
  input  logic [DATA_W-1:0] ALUOut,
  input  logic [DATA_W-1:0] ReadData,
  input  logic [DATA_W-1:0] pc_plus_4,
  input  logic [ADDR_W-1:0] AddrA,
  input  logic [ADDR_W-1:0] AddrB,
  output logic [DATA_W-1:0] DataA,
  output logic [DATA_W-1:0] DataB,
  output logic [DATA_W-1:0] WrData,
  output logic [CNT_W-1:0]  wb_commit_cnt
);

  localparam int NREGS = 2**ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];
  logic [CNT_W-1:0]  commit_cnt;
  logic              commit;

  function automatic logic [DATA_W-1:0] wb_select(
    input logic [1:0]        sel,
    input logic [DATA_W-1:0] alu,
    input logic [DATA_W-1:0] mem,
    input logic [DATA_W-1:0] link
  );
    case (sel)
      2'b01:   return mem;
      2'b10:   return link;
      default: return alu;
    endcase
  endfunction

  assign WrData = wb_select(MemToReg, ALUOut, ReadData, pc_plus_4);

  // Writes to $0 are dropped. A held reset also blocks the commit, so the
  // bypass path cannot leak WrData while the file is being cleared.
  assign commit = RegWr && (AddrC != '0) && reset;

  // Commit stage: register file and commit counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      commit_cnt <= '0;
    end else if (commit) begin
      regs[AddrC] <= WrData;
      commit_cnt  <= commit_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign wb_commit_cnt = commit_cnt;

  always_comb begin
    DataA = (AddrA == '0) ? '0 : regs[AddrA];
    DataB = (AddrB == '0) ? '0 : regs[AddrB];
`ifdef WB_BYPASS_EN
    // Write-first: the value committing at the next edge is visible now.
    if (commit && (AddrA == AddrC)) DataA = WrData;
    if (commit && (AddrB == AddrC)) DataB = WrData;
`else
    // Read-old: the hazard unit stalls ID on an AddrC match.
`endif
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile. A behavioural model of the register file is
// checked every cycle, and literal expectations pin the key scenarios.
module tb_wb_regfile;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 8;   // narrow counter so the wrap is reachable

  logic              clk = 1'b0;
  logic              reset;
  logic              RegWr;
  logic [1:0]        MemToReg;
  logic [ADDR_W-1:0] AddrC, AddrA, AddrB;
  logic [DATA_W-1:0] ALUOut, ReadData, pc_plus_4;
  logic [DATA_W-1:0] DataA, DataB, WrData;
  logic [CNT_W-1:0]  wb_commit_cnt;

  wb_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .RegWr(RegWr), .MemToReg(MemToReg),
    .AddrC(AddrC), .ALUOut(ALUOut), .ReadData(ReadData), .pc_plus_4(pc_plus_4),
    .AddrA(AddrA), .AddrB(AddrB), .DataA(DataA), .DataB(DataB),
    .WrData(WrData), .wb_commit_cnt(wb_commit_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // Behavioural model
  logic [DATA_W-1:0] m_regs [32];
  int unsigned       m_cnt;

  function automatic logic [DATA_W-1:0] m_src();
    if (MemToReg == 2'd1) return ReadData;
    if (MemToReg == 2'd2) return pc_plus_4;
    return ALUOut;
  endfunction

  function automatic logic [DATA_W-1:0] m_read(input logic [ADDR_W-1:0] a);
    if (a == 0) return '0;
`ifdef WB_BYPASS_EN
    if (reset === 1'b1 && RegWr && AddrC != 0 && AddrC == a) return m_src();
`endif
    return m_regs[a];
  endfunction

  always @(posedge clk or negedge reset) begin
    if (reset === 1'b0) begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_cnt = 0;
    end else if (RegWr && AddrC != 0) begin
      m_regs[AddrC] = m_src();
      m_cnt = (m_cnt + 1) % (1 << CNT_W);
    end
  end

  task automatic chk(input string name, input logic [DATA_W-1:0] act,
                     input logic [DATA_W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model DataA", DataA, m_read(AddrA));
      chk("model DataB", DataB, m_read(AddrB));
      chk("model WrData", WrData, m_src());
      chk("model cnt", DATA_W'(wb_commit_cnt), DATA_W'(m_cnt));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic look();
    @(negedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; RegWr = 1'b0; MemToReg = 2'd0; AddrC = '0; AddrA = '0; AddrB = '0;
    ALUOut = '0; ReadData = '0; pc_plus_4 = '0;
    #2 reset = 1'b0;
    chk_en = 1'b1;
    tick(); tick();
    reset = 1'b1;

    // 1: everything reads zero after reset
    for (int i = 0; i < 32; i++) begin
      AddrA = ADDR_W'(i); AddrB = ADDR_W'(31 - i);
      look();
      chk("reset DataA", DataA, 32'h0);
      chk("reset DataB", DataB, 32'h0);
    end
    chk("reset cnt", DATA_W'(wb_commit_cnt), 32'h0);

    // 2: load result into $5
    tick();
    RegWr = 1'b1; AddrC = 5'd5; MemToReg = 2'b01; ReadData = 32'hDEADBEEF; AddrA = 5'd5;
    tick();
    RegWr = 1'b0;
    look();
    chk("load $5", DataA, 32'hDEADBEEF);
    chk("load cnt", DATA_W'(wb_commit_cnt), 32'd1);

    // 3: write to $0 is dropped and not counted
    tick();
    RegWr = 1'b1; AddrC = 5'd0; MemToReg = 2'b00; ALUOut = 32'h1234; AddrA = 5'd0;
    look();
    chk("WrData alu", WrData, 32'h1234);
    tick();
    RegWr = 1'b0;
    look();
    chk("$0 read", DataA, 32'h0);
    chk("$0 cnt", DATA_W'(wb_commit_cnt), 32'd1);

    // 4: same-cycle read of the register being written
    tick();
    RegWr = 1'b1; AddrC = 5'd31; MemToReg = 2'b10; pc_plus_4 = 32'h00400008; AddrB = 5'd31;
    look();
`ifdef WB_BYPASS_EN
    chk("same-cycle $31", DataB, 32'h00400008);
`else
    chk("same-cycle $31", DataB, 32'h0);
`endif
    tick();
    RegWr = 1'b0;
    look();
    chk("after-edge $31", DataB, 32'h00400008);
    chk("link cnt", DATA_W'(wb_commit_cnt), 32'd2);

    // MemToReg 11 selects ALUOut; both ports on the same address
    tick();
    RegWr = 1'b1; AddrC = 5'd9; MemToReg = 2'b11; ALUOut = 32'hCAFE0011;
    ReadData = 32'h0; pc_plus_4 = 32'h0; AddrA = 5'd9; AddrB = 5'd9;
    tick();
    RegWr = 1'b0;
    look();
    chk("sel11 DataA", DataA, 32'hCAFE0011);
    chk("sel11 DataB", DataB, 32'hCAFE0011);
    chk("sel11 cnt", DATA_W'(wb_commit_cnt), 32'd3);

    // 5: drive the counter to all-ones, then wrap
    tick();
    MemToReg = 2'b00; RegWr = 1'b1;
    for (int k = 0; k < 252; k++) begin
      AddrC = ADDR_W'(1 + (k % 30)); ALUOut = DATA_W'(k);
      tick();
    end
    RegWr = 1'b0;
    look();
    chk("cnt full", DATA_W'(wb_commit_cnt), 32'hFF);
    tick();
    RegWr = 1'b1; AddrC = 5'd12; ALUOut = 32'h0C0C0C0C;
    tick();
    RegWr = 1'b0;
    look();
    chk("cnt wrap", DATA_W'(wb_commit_cnt), 32'h0);

    // 6: reset asserted in the middle of a write
    tick();
    RegWr = 1'b1; AddrC = 5'd7; ALUOut = 32'hA5A5A5A5;
    tick();
    RegWr = 1'b0; AddrA = 5'd7; AddrB = 5'd5;
    look();
    chk("pre-reset $7", DataA, 32'hA5A5A5A5);
    tick();
    RegWr = 1'b1; AddrC = 5'd7; ALUOut = 32'h11112222;
    #2 reset = 1'b0;
    look();
    chk("mid-reset $7", DataA, 32'h0);
    chk("mid-reset cnt", DATA_W'(wb_commit_cnt), 32'h0);
    tick();
    look();
    chk("held-reset $7", DataA, 32'h0);
    chk("held-reset $5", DataB, 32'h0);
    tick();
    reset = 1'b1;
    tick();
    RegWr = 1'b0;
    look();
    chk("post-reset $7", DataA, 32'h11112222);
    chk("post-reset cnt", DATA_W'(wb_commit_cnt), 32'd1);

    tick(); tick();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
